// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-wide data RAM behind a one-entry posted store buffer, registered read port.
// Optional feature macro: DMEM_STORE_FWD_EN (store-to-load forwarding; otherwise busy_o stalls hazard reads).
module dmem_ctrl #(
  parameter int          WORDS_LOG2 = 8,
  parameter logic [15:0] REGION_HI  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        d_we,
  input  logic        is_sw_i,
  input  logic        is_sh_i,
  input  logic        is_sb_i,
  output logic [31:0] d_rdata,
  output logic        misalign_o,
  output logic        busy_o
);
  localparam int DEPTH = 1 << WORDS_LOG2;

  logic                  hit;
  logic [WORDS_LOG2-1:0] idx;
  logic [3:0]            wb_be_d;
  logic [31:0]           wb_data_d;
  logic                  st_misalign;
  logic                  st_accept;
  logic                  st_reject;
  logic                  wb_match;
  logic                  unused_addr;

  logic                  wb_valid_q;
  logic [WORDS_LOG2-1:0] wb_idx_q;
  logic [3:0]            wb_be_q;
  logic [31:0]           wb_data_q;
  logic                  misalign_q;
  logic                  rd_hit_q;
  logic [31:0]           rd_word_q;
  logic [3:0][7:0]       mem [DEPTH];

  assign hit         = (d_addr[31:16] == REGION_HI);
  assign idx         = d_addr[WORDS_LOG2+1:2];
  assign unused_addr = ^d_addr[15:2];
  assign wb_match    = wb_valid_q && (wb_idx_q == idx);

  // Store data is replicated across lanes so the byte enables alone select what lands.
  always_comb begin
    wb_be_d     = 4'b0000;
    wb_data_d   = d_wdata;
    st_misalign = 1'b0;
    if (is_sw_i) begin
      wb_be_d     = 4'b1111;
      st_misalign = (d_addr[1:0] != 2'b00);
    end else if (is_sh_i) begin
      wb_be_d     = d_addr[1] ? 4'b1100 : 4'b0011;
      wb_data_d   = {2{d_wdata[15:0]}};
      st_misalign = d_addr[0];
    end else if (is_sb_i) begin
      wb_be_d   = 4'b0001 << d_addr[1:0];
      wb_data_d = {4{d_wdata[7:0]}};
    end
  end

  assign st_accept = d_we && hit && !st_misalign && (wb_be_d != 4'b0000);
  assign st_reject = d_we && hit && st_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_idx_q   <= '0;
      wb_be_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      wb_valid_q <= st_accept;
      misalign_q <= st_reject;
      rd_hit_q   <= hit;
      if (st_accept) begin
        wb_idx_q  <= idx;
        wb_be_q   <= wb_be_d;
        wb_data_q <= wb_data_d;
      end
    end
  end

  // Buffered entry always drains on the edge after capture; read sees pre-write contents.
  always_ff @(posedge clk) begin
    if (wb_valid_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be_q[b]) mem[wb_idx_q][b] <= wb_data_q[8*b +: 8];
      end
    end
    rd_word_q <= mem[idx];
  end

  assign misalign_o = misalign_q;

`ifdef DMEM_STORE_FWD_EN
  logic [31:0] fwd_mask_d;
  logic [31:0] fwd_mask_q;
  logic [31:0] fwd_data_q;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fwd_mask
    assign fwd_mask_d[8*gi +: 8] = {8{wb_match && wb_be_q[gi]}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= wb_data_q;
    end
  end

  assign d_rdata = rd_hit_q ? ((rd_word_q & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q)) : 32'h0;
  assign busy_o  = 1'b0;
`else
  assign d_rdata = rd_hit_q ? rd_word_q : 32'h0;
  assign busy_o  = hit && wb_match && !d_we;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed test-plan sequences plus random stores/loads against a word-array model.
// Honours DMEM_STORE_FWD_EN the same way as the design.
module tb_dmem_ctrl;
  localparam logic [2:0] W_SW = 3'b100;
  localparam logic [2:0] W_SH = 3'b010;
  localparam logic [2:0] W_SB = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_we = 1'b0;
  logic        is_sw_i = 1'b0;
  logic        is_sh_i = 1'b0;
  logic        is_sb_i = 1'b0;
  logic [31:0] d_rdata;
  logic        misalign_o;
  logic        busy_o;

  dmem_ctrl #(.WORDS_LOG2(8), .REGION_HI(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .is_sw_i(is_sw_i), .is_sh_i(is_sh_i), .is_sb_i(is_sb_i),
    .d_rdata(d_rdata), .misalign_o(misalign_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: memory as the core sees it (stores visible immediately), plus an undo record
  // for the most recent store so a reset before its commit can discard it.
  logic [31:0] mdl   [256];
  bit          known [256];
  bit          pend_valid = 1'b0;
  logic [7:0]  pend_idx = '0;
  logic [31:0] pend_old = '0;
  bit          pend_known = 1'b0;
  bit          last_busy_exp = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic [2:0] w, output logic [31:0] rd, output logic mis);
    logic        hit, bad, acc, exp_busy, chk_rd;
    logic [7:0]  ix;
    logic [31:0] exp_rd, nw;
    int          hoff, boff;
    d_addr = a; d_wdata = wd; d_we = we;
    {is_sw_i, is_sh_i, is_sb_i} = w;
    hit      = (a[31:16] == 16'h0000);
    ix       = a[9:2];
    bad      = we && ((w[2] && a[1:0] != 2'b00) || (w[1] && a[0]));
    acc      = we && hit && (w != 3'b000) && !bad;
    exp_busy = 1'b0;
    chk_rd   = !hit || known[ix];
    exp_rd   = hit ? mdl[ix] : 32'h0;
`ifndef DMEM_STORE_FWD_EN
    if (hit && pend_valid && pend_idx == ix) begin
      exp_busy = !we;
      chk_rd   = 1'b0;
    end
`endif
    last_busy_exp = exp_busy;
    @(negedge clk);
    check_val("busy", {31'b0, busy_o}, {31'b0, exp_busy});
    @(posedge clk);
    #1;
    rd  = d_rdata;
    mis = misalign_o;
    if (chk_rd) check_val("rdata", d_rdata, exp_rd);
    check_val("misalign", {31'b0, misalign_o}, {31'b0, hit && bad});
    pend_valid = acc;
    pend_idx   = ix;
    if (acc) begin
      pend_old   = mdl[ix];
      pend_known = known[ix];
      nw   = mdl[ix];
      hoff = a[1] ? 16 : 0;
      boff = 8 * int'(a[1:0]);
      if (w[2]) begin
        nw = wd;
        known[ix] = 1'b1;
      end else if (w[1]) begin
        nw[hoff +: 16] = wd[15:0];
      end else begin
        nw[boff +: 8] = wd[7:0];
      end
      mdl[ix] = nw;
    end
  endtask

  task automatic read_word(input logic [31:0] a, output logic [31:0] rd);
    logic m;
    step(a, 32'h0, 1'b0, 3'b000, rd, m);
    if (last_busy_exp) step(a, 32'h0, 1'b0, 3'b000, rd, m);
  endtask

  initial begin
    logic [31:0] rd;
    logic        mis;
    for (int i = 0; i < 256; i++) begin
      mdl[i]   = '0;
      known[i] = 1'b0;
    end

    repeat (2) @(posedge clk);
    #1;
    check_val("reset_rdata", d_rdata, 32'h0);
    check_val("reset_misalign", {31'b0, misalign_o}, 32'h0);
    check_val("reset_busy", {31'b0, busy_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 256; i++) begin
      logic [31:0] a;
      a = {22'b0, i[7:0], 2'b00};
      step(a, $urandom, 1'b1, W_SW, rd, mis);
    end

    step(32'h0, 32'hDEADBEEF, 1'b1, W_SW, rd, mis);
    read_word(32'h0, rd);
    check_val("plan_sw_read", rd, 32'hDEADBEEF);

    step(32'h4, 32'h11223344, 1'b1, W_SW, rd, mis);
    step(32'h6, 32'h000000AA, 1'b1, W_SB, rd, mis);
    read_word(32'h4, rd);
    check_val("plan_sb_merge", rd, 32'h11AA3344);
    step(32'h4, 32'h0000BEEF, 1'b1, W_SH, rd, mis);
    read_word(32'h4, rd);
    check_val("plan_sh_merge", rd, 32'h11AABEEF);

    step(32'h8, 32'h1, 1'b1, W_SW, rd, mis);
    step(32'hC, 32'h2, 1'b1, W_SW, rd, mis);
    step(32'h8, 32'h3, 1'b1, W_SW, rd, mis);
    read_word(32'h8, rd);
    check_val("plan_b2b_08", rd, 32'h3);
    read_word(32'hC, rd);
    check_val("plan_b2b_0c", rd, 32'h2);

    step(32'h1, 32'hCAFEF00D, 1'b1, W_SW, rd, mis);
    check_val("plan_mis_sw", {31'b0, mis}, 32'h1);
    step(32'h3, 32'h00001234, 1'b1, W_SH, rd, mis);
    check_val("plan_mis_sh", {31'b0, mis}, 32'h1);
    read_word(32'h0, rd);
    check_val("plan_mis_keep0", rd, 32'hDEADBEEF);
    read_word(32'h4, rd);
    check_val("plan_mis_keep4", rd, 32'h11AABEEF);

    step(32'h0001_0000, 32'h55, 1'b1, W_SW, rd, mis);
    check_val("plan_miss_nomis", {31'b0, mis}, 32'h0);
    read_word(32'h0001_0000, rd);
    check_val("plan_miss_read", rd, 32'h0);
    read_word(32'h0, rd);
    check_val("plan_miss_keep0", rd, 32'hDEADBEEF);

    step(32'h10, 32'h12345678, 1'b1, W_SW, rd, mis);
    read_word(32'h10, rd);
    step(32'h10, 32'h77, 1'b1, W_SW, rd, mis);
    d_we = 1'b0;
    {is_sw_i, is_sh_i, is_sb_i} = 3'b000;
    rst_n = 1'b0;
    if (pend_valid) begin
      mdl[pend_idx]   = pend_old;
      known[pend_idx] = pend_known;
    end
    pend_valid = 1'b0;
    #1;
    check_val("rst_mid_rdata", d_rdata, 32'h0);
    check_val("rst_mid_misalign", {31'b0, misalign_o}, 32'h0);
    check_val("rst_mid_busy", {31'b0, busy_o}, 32'h0);
    @(posedge clk);
    #1;
    check_val("rst_hold_rdata", d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    read_word(32'h10, rd);
    check_val("plan_rst_discard", rd, 32'h12345678);

    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a;
      logic [2:0]  w;
      logic        we;
      a  = {($urandom_range(0, 7) == 0) ? 16'h0001 : 16'h0000, 11'b0, 5'($urandom_range(0, 31))};
      we = 1'($urandom_range(0, 1));
      w  = we ? (3'b001 << $urandom_range(0, 2)) : 3'b000;
      step(a, $urandom, we, w, rd, mis);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-side memory controller sitting directly downstream of `cpu_core`'s data port. It consumes `d_addr`/`d_wdata`/`d_we` and the store-width strobes, merges byte/halfword/word stores into a word-wide RAM through a one-entry posted write buffer, and returns a registered `d_rdata` one cycle after the address is presented. It also forwards buffered store bytes to later loads and flags misaligned stores.

## Interface
Parameters:
- `WORDS_LOG2`, 8: RAM depth is 2^WORDS_LOG2 words, indexed by `d_addr[WORDS_LOG2+1:2]`.
- `REGION_HI`, 16'h0000: value of `d_addr[31:16]` that selects this RAM.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `d_addr` in 32: byte address of the current access.
- `d_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `d_we` in 1: store request this cycle.
- `is_sw_i`, `is_sh_i`, `is_sb_i` in 1 each: store width, one-hot while `d_we`=1.
- `d_rdata` out 32: registered read word for the address presented the previous cycle.
- `misalign_o` out 1: one-cycle pulse, registered, for a rejected misaligned store.
- `busy_o` out 1: load-hazard stall request (only driven without forwarding; see Configuration).

## Operation
- Region hit: `hit = (d_addr[31:16] == REGION_HI)`. Misses: stores dropped silently (no `misalign_o`), reads return 32'h0.
- Byte enables: sw -> 4'b1111; sh -> 4'b0011 or 4'b1100 per `d_addr[1]`; sb -> one-hot per `d_addr[1:0]`. Data is replicated into the lane(s) (`{4{b}}`, `{2{h}}`).
- Misalignment: sw with `d_addr[1:0]!=0`, or sh with `d_addr[0]=1` -> store rejected, `misalign_o`=1 next cycle. No buffer or RAM change.
- Write buffer: `wb_valid`, `wb_idx`, `wb_be[3:0]`, `wb_data[31:0]`. An accepted store loads the buffer at edge N. The buffer commits to RAM (per-byte enables) at edge N+1, unconditionally.
- Back-to-back stores: commit of entry A and capture of store B happen on the same edge; no stall and no loss.
- RAM has one synchronous read port and one byte-enabled write port. Contents are not reset.
- Read: `d_rdata` at edge N+1 equals RAM[idx] sampled at edge N, overlaid byte-wise with `wb_data` where `wb_valid && wb_idx==idx && wb_be[i]`.
- Same-cycle store and read to the same word: `d_rdata` reflects the pre-store contents (read-before-write).
- Sub-word load extraction and sign extension belong to `cpu_core`. This block always returns the full word.

## Timing
- Reset (async assert, sync deassert use): `d_rdata`=0, `misalign_o`=0, `busy_o`=0, `wb_valid`=0. Any buffered store is discarded on reset mid-operation.
- Read latency: 1 cycle, address to `d_rdata`.
- Store visibility: visible via forwarding from cycle N+1, and in RAM from edge N+1.
- `misalign_o`: high exactly one cycle per rejected store.
- No backpressure with forwarding enabled; `busy_o` is held 0.

## Configuration
- `DMEM_STORE_FWD_EN` defined: byte-wise buffer-to-read forwarding as above; `busy_o` is tied 0.
- `DMEM_STORE_FWD_EN` undefined: no forwarding mux. A read with `hit && wb_valid && wb_idx==idx && !d_we` asserts `busy_o` combinationally for that cycle. The `d_rdata` returned for that cycle is don't-care. The core holds the address, and the re-read after commit returns correct data, giving a 1-cycle penalty.

## Test plan
- Reset, then sw 0xDEADBEEF @0x00, read @0x00 the next cycle -> `d_rdata`=0xDEADBEEF the following cycle (forwarded; `busy_o`=1 for one cycle when built without fwd).
- RAM word 0x11223344 @0x04; sb 0xAA @0x06; read @0x04 -> 0x11AA3344. sh 0xBEEF @0x04 -> read gives 0x11AABEEF.
- Back-to-back sw 1 @0x08, sw 2 @0x0C, sw 3 @0x08, then reads -> 0x08=3, 0x0C=2; no `busy_o`.
- sw @0x01 and sh @0x03 -> `misalign_o` pulses once each; RAM words 0x00/0x04 unchanged.
- sw 0x55 @0x0001_0000 (region miss) -> no write; read there returns 0; RAM index 0 unchanged.
- sw 0x77 @0x10, assert `rst_n`=0 before commit edge -> after reset, read @0x10 returns prior contents, `d_rdata`=0 during reset.
